panel_update_scheduler: RTL and testbench

//  Shares the four display bands (panels 0-3, top to bottom) between sensor requesters.

---
 rtl/panel_update_scheduler.sv | 179 +++++++++++++++++
 tb/tb_panel_update_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/panel_update_scheduler.sv
// Panel update scheduler: round-robin capture of requester values into per-panel shadows,
// committed to the display side only at frame start. Macro STALE_TIMEOUT_EN adds stale flags.
module panel_update_scheduler #(
  parameter int NUM_PANELS = 4,
  parameter int DATA_W     = 16
`ifdef STALE_TIMEOUT_EN
  ,parameter int TIMEOUT_FRAMES = 60
`endif
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET_N,
  input  logic                         VGA_VS,
  input  logic [NUM_PANELS-1:0]        req_valid,
  input  logic [NUM_PANELS*DATA_W-1:0] req_data,
  output logic [NUM_PANELS-1:0]        req_ready,
  output logic [NUM_PANELS*DATA_W-1:0] panel_value,
  output logic [NUM_PANELS-1:0]        panel_updated,
  output logic                         frame_commit,
  output logic [NUM_PANELS-1:0]        panel_stale
);

  localparam int PTR_W = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1;

  typedef enum logic [1:0] {ARB, XFER, COMMIT} state_t;

  state_t                       state_q, state_d;
  logic [PTR_W-1:0]             rrPtr_q, rrPtr_d;
  logic [PTR_W-1:0]             gnt_q, gnt_d;
  logic [NUM_PANELS-1:0]        reqReady_q, reqReady_d;
  logic [NUM_PANELS-1:0]        pend_q, pend_d;
  logic [NUM_PANELS-1:0]        panelUpdated_q, panelUpdated_d;
  logic [NUM_PANELS*DATA_W-1:0] shadow_q, shadow_d;
  logic [NUM_PANELS*DATA_W-1:0] panelValue_q, panelValue_d;
  logic                         commitPend_q, commitPend_d;
  logic                         frameCommit_q, frameCommit_d;
  logic                         vs0_q, vs1_q;
  logic                         vsFall, doCommit;
  logic [PTR_W-1:0]             upIdx, anyIdx, grantIdx;
  logic                         upFound, grantFound;

  assign vsFall   = vs1_q & ~vs0_q;
  assign doCommit = (state_q == ARB) && commitPend_q;

  // First valid index above the pointer wins; otherwise wrap to the lowest valid index.
  always_comb begin
    upIdx      = '0;
    anyIdx     = '0;
    upFound    = 1'b0;
    grantFound = |req_valid;
    for (int i = NUM_PANELS - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        anyIdx = PTR_W'(i);
        if (i > int'(rrPtr_q)) begin
          upIdx   = PTR_W'(i);
          upFound = 1'b1;
        end
      end
    end
    grantIdx = upFound ? upIdx : anyIdx;
  end

  always_comb begin
    state_d        = state_q;
    rrPtr_d        = rrPtr_q;
    gnt_d          = gnt_q;
    reqReady_d     = '0;
    pend_d         = pend_q;
    shadow_d       = shadow_q;
    panelValue_d   = panelValue_q;
    panelUpdated_d = '0;
    frameCommit_d  = 1'b0;
    commitPend_d   = commitPend_q | vsFall;
    unique case (state_q)
      ARB: begin
        if (commitPend_q) begin
          // A fall seen on this very edge belongs to the next frame, so it re-arms the flag.
          state_d        = COMMIT;
          commitPend_d   = vsFall;
          frameCommit_d  = 1'b1;
          panelUpdated_d = pend_q;
          pend_d         = '0;
          for (int i = 0; i < NUM_PANELS; i++) begin
            if (pend_q[i]) panelValue_d[i*DATA_W +: DATA_W] = shadow_q[i*DATA_W +: DATA_W];
          end
        end else if (grantFound) begin
          state_d = XFER;
          gnt_d   = grantIdx;
          for (int i = 0; i < NUM_PANELS; i++) reqReady_d[i] = (grantIdx == PTR_W'(i));
        end
      end
      XFER: begin
        state_d = ARB;
        for (int i = 0; i < NUM_PANELS; i++) begin
          if ((gnt_q == PTR_W'(i)) && req_valid[i]) begin
            shadow_d[i*DATA_W +: DATA_W] = req_data[i*DATA_W +: DATA_W];
            pend_d[i] = 1'b1;
            rrPtr_d   = gnt_q;
          end
        end
      end
      COMMIT:  state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q        <= ARB;
      rrPtr_q        <= PTR_W'(NUM_PANELS - 1);
      gnt_q          <= '0;
      reqReady_q     <= '0;
      pend_q         <= '0;
      shadow_q       <= '0;
      panelValue_q   <= '0;
      panelUpdated_q <= '0;
      frameCommit_q  <= 1'b0;
      commitPend_q   <= 1'b0;
      vs0_q          <= 1'b1;
      vs1_q          <= 1'b1;
    end else begin
      state_q        <= state_d;
      rrPtr_q        <= rrPtr_d;
      gnt_q          <= gnt_d;
      reqReady_q     <= reqReady_d;
      pend_q         <= pend_d;
      shadow_q       <= shadow_d;
      panelValue_q   <= panelValue_d;
      panelUpdated_q <= panelUpdated_d;
      frameCommit_q  <= frameCommit_d;
      commitPend_q   <= commitPend_d;
      vs0_q          <= VGA_VS;
      vs1_q          <= vs0_q;
    end
  end

  assign req_ready     = reqReady_q;
  assign panel_value   = panelValue_q;
  assign panel_updated = panelUpdated_q;
  assign frame_commit  = frameCommit_q;

`ifdef STALE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);

  logic [CNT_W-1:0]      staleCnt_q [NUM_PANELS];
  logic [CNT_W-1:0]      staleCnt_d [NUM_PANELS];
  logic [NUM_PANELS-1:0] stale_q, stale_d;

  // Counts frames since the last commit of each panel, saturating at the timeout.
  always_comb begin
    stale_d = stale_q;
    for (int i = 0; i < NUM_PANELS; i++) begin
      staleCnt_d[i] = staleCnt_q[i];
      if (doCommit) begin
        if (pend_q[i]) begin
          staleCnt_d[i] = '0;
        end else if (staleCnt_q[i] != CNT_W'(TIMEOUT_FRAMES)) begin
          staleCnt_d[i] = staleCnt_q[i] + 1'b1;
        end
        stale_d[i] = (staleCnt_d[i] == CNT_W'(TIMEOUT_FRAMES));
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      stale_q <= '0;
      for (int i = 0; i < NUM_PANELS; i++) staleCnt_q[i] <= '0;
    end else begin
      stale_q <= stale_d;
      for (int i = 0; i < NUM_PANELS; i++) staleCnt_q[i] <= staleCnt_d[i];
    end
  end

  assign panel_stale = stale_q;
`else
  assign panel_stale = '0;
`endif

endmodule

// File: tb/tb_panel_update_scheduler.sv
// Directed bench for panel_update_scheduler: grant order and commit contents are scoreboarded.
// With STALE_TIMEOUT_EN defined the DUT is built with a 3-frame timeout.
module tb_panel_update_scheduler;

  localparam int NP = 4;
  localparam int DW = 16;
  localparam int STALE_T = 3;

  typedef struct {
    logic [NP*DW-1:0] value;
    logic [NP-1:0]    upd;
  } commitExp_t;

  logic             CLOCK_50 = 1'b0;
  logic             RESET_N;
  logic             VGA_VS;
  logic [NP-1:0]    req_valid;
  logic [NP*DW-1:0] req_data;
  logic [NP-1:0]    req_ready;
  logic [NP*DW-1:0] panel_value;
  logic [NP-1:0]    panel_updated;
  logic             frame_commit;
  logic [NP-1:0]    panel_stale;

  int               checks = 0;
  int               errors = 0;
  int               grantQ[$];
  commitExp_t       commitQ[$];
  logic [NP*DW-1:0] committed;
  logic [NP*DW-1:0] expVal;
  int               staleCnt[NP];

  always #10 CLOCK_50 = ~CLOCK_50;

  panel_update_scheduler #(
    .NUM_PANELS(NP),
    .DATA_W(DW)
`ifdef STALE_TIMEOUT_EN
    ,.TIMEOUT_FRAMES(STALE_T)
`endif
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N(RESET_N),
    .VGA_VS(VGA_VS),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .panel_value(panel_value),
    .panel_updated(panel_updated),
    .frame_commit(frame_commit),
    .panel_stale(panel_stale)
  );

  function automatic logic [NP-1:0] onehot(input int i);
    logic [NP-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int p, input logic [DW-1:0] v);
    req_data[p*DW +: DW] = v;
    req_valid[p]         = 1'b1;
  endtask

  // Raises one request and waits for its grant; optionally drops VS in the transfer cycle.
  task automatic sendOne(input int p, input logic [DW-1:0] v, input bit dropVs);
    int waited;
    int expG;
    waited = 0;
    grantQ.push_back(p);
    applyStimulus(p, v);
    do begin
      @(negedge CLOCK_50);
      waited++;
    end while (req_ready === '0 && waited < 20);
    expG = grantQ.pop_front();
    checkOutput($sformatf("grant_p%0d", p), 64'(req_ready), 64'(onehot(expG)));
    if (dropVs) VGA_VS = 1'b0;
    @(negedge CLOCK_50);
    req_valid[p] = 1'b0;
    checkOutput($sformatf("ready_off_p%0d", p), 64'(req_ready), 64'd0);
  endtask

  task automatic pushCommit(input logic [NP-1:0] upd, input logic [NP*DW-1:0] value);
    commitExp_t e;
    e.value = value;
    e.upd   = upd;
    commitQ.push_back(e);
  endtask

  // Display side must hold until the commit pulse, then match the scoreboard entry.
  task automatic waitCommit(input string tag);
    commitExp_t    e;
    int            waited;
    logic [NP-1:0] expStale;
    waited = 0;
    e = commitQ.pop_front();
    @(negedge CLOCK_50);
    while (frame_commit !== 1'b1 && waited < 20) begin
      checkOutput({tag, "_hold"}, 64'(panel_value), 64'(committed));
      @(negedge CLOCK_50);
      waited++;
    end
    checkOutput({tag, "_fc"}, 64'(frame_commit), 64'd1);
    checkOutput({tag, "_val"}, 64'(panel_value), 64'(e.value));
    checkOutput({tag, "_upd"}, 64'(panel_updated), 64'(e.upd));
    committed = e.value;
    for (int i = 0; i < NP; i++) begin
      if (e.upd[i]) staleCnt[i] = 0;
      else if (staleCnt[i] < STALE_T) staleCnt[i]++;
`ifdef STALE_TIMEOUT_EN
      expStale[i] = (staleCnt[i] == STALE_T);
`else
      expStale[i] = 1'b0;
`endif
    end
    @(negedge CLOCK_50);
    checkOutput({tag, "_pulse"}, 64'({frame_commit, panel_updated}), 64'd0);
    checkOutput({tag, "_stale"}, 64'(panel_stale), 64'(expStale));
  endtask

  initial begin
    int expG;
    RESET_N   = 1'b0;
    VGA_VS    = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NP; i++) req_data[i*DW +: DW] = DW'(16'hA000 + i);
    committed = '0;
    for (int i = 0; i < NP; i++) staleCnt[i] = 0;

    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_value", 64'(panel_value), 64'd0);
    checkOutput("rst_upd", 64'(panel_updated), 64'd0);
    checkOutput("rst_fc", 64'(frame_commit), 64'd0);
    checkOutput("rst_stale", 64'(panel_stale), 64'd0);
    RESET_N = 1'b1;

    $display("[TB] round-robin with all requesters valid");
    grantQ.push_back(0);
    grantQ.push_back(1);
    grantQ.push_back(2);
    grantQ.push_back(3);
    grantQ.push_back(0);
    for (int n = 0; n < 5; n++) begin
      @(negedge CLOCK_50);
      expG = grantQ.pop_front();
      checkOutput($sformatf("rr_grant%0d", n), 64'(req_ready), 64'(onehot(expG)));
      @(negedge CLOCK_50);
      checkOutput($sformatf("rr_gap%0d", n), 64'(req_ready), 64'd0);
    end
    req_valid = '0;
    pushCommit(4'b1111, 64'hA003_A002_A001_A000);
    VGA_VS = 1'b0;
    waitCommit("frame_all");
    VGA_VS = 1'b1;

    $display("[TB] single update on panel 2");
    sendOne(2, 16'h1234, 1'b0);
    expVal = committed;
    expVal[32 +: 16] = 16'h1234;
    pushCommit(4'b0100, expVal);
    repeat (3) @(negedge CLOCK_50);
    checkOutput("p2_no_early", 64'(panel_value), 64'(committed));
    VGA_VS = 1'b0;
    waitCommit("frame_p2");
    VGA_VS = 1'b1;

    $display("[TB] panel 1 updated twice in one frame");
    sendOne(1, 16'hAAAA, 1'b0);
    sendOne(1, 16'h5555, 1'b0);
    expVal = committed;
    expVal[16 +: 16] = 16'h5555;
    pushCommit(4'b0010, expVal);
    VGA_VS = 1'b0;
    waitCommit("frame_p1");
    VGA_VS = 1'b1;

    $display("[TB] VS falls during panel 3 transfer");
    expVal = committed;
    expVal[48 +: 16] = 16'h00FF;
    pushCommit(4'b1000, expVal);
    sendOne(3, 16'h00FF, 1'b1);
    waitCommit("frame_p3_vs");
    VGA_VS = 1'b1;

    $display("[TB] frames with no updates");
    for (int f = 0; f < 2; f++) begin
      repeat (2) @(negedge CLOCK_50);
      pushCommit(4'b0000, committed);
      VGA_VS = 1'b0;
      waitCommit($sformatf("frame_empty%0d", f));
      VGA_VS = 1'b1;
    end

    $display("[TB] panel 0 returns after silence");
    sendOne(0, 16'hBEEF, 1'b0);
    expVal = committed;
    expVal[0 +: 16] = 16'hBEEF;
    pushCommit(4'b0001, expVal);
    VGA_VS = 1'b0;
    waitCommit("frame_p0_back");
    VGA_VS = 1'b1;

    $display("[TB] reset discards an uncommitted shadow");
    sendOne(2, 16'h7777, 1'b0);
    RESET_N = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    checkOutput("rst2_value", 64'(panel_value), 64'd0);
    checkOutput("rst2_stale", 64'(panel_stale), 64'd0);
    committed = '0;
    for (int i = 0; i < NP; i++) staleCnt[i] = 0;
    pushCommit(4'b0000, 64'd0);
    VGA_VS = 1'b0;
    waitCommit("frame_after_rst");
    VGA_VS = 1'b1;

    repeat (2) @(negedge CLOCK_50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
